// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32I constants and fetch-stage types
package rv32_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
   localparam logic [6:0] OPC_STORE  = 7'b010_0011;
   localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
   localparam logic [6:0] OPC_JAL    = 7'b110_1111;
   localparam logic [6:0] OPC_JALR   = 7'b110_0111;
   localparam logic [6:0] OPC_SYSTEM = 7'b111_0011;

   localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
   localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

   // Redirect targets are forced onto a word boundary
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// rtl/fetch_perf_cnt.sv - fetch/stall/flush event counters
module fetch_perf_cnt (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        fetch_en_i,
   input  logic        stall_en_i,
   input  logic        flush_en_i,
   output logic [31:0] perf_fetch_o,
   output logic [31:0] perf_stall_o,
   output logic [31:0] perf_flush_o
);

   // Free-running counters, each advancing only on its event; wrap at 2^32
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         perf_fetch_o <= 32'd0;
         perf_stall_o <= 32'd0;
         perf_flush_o <= 32'd0;
      end else begin
         if (fetch_en_i) perf_fetch_o <= perf_fetch_o + 32'd1;
         if (stall_en_i) perf_stall_o <= perf_stall_o + 32'd1;
         if (flush_en_i) perf_flush_o <= perf_flush_o + 32'd1;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I instruction fetch stage with IF/ID register
module fetch_stage
   import rv32_pkg::*;
#(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR      = 32'h0000_0013,
   parameter bit          HALT_ON_EBREAK = 1'b1
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        stall_en_i,
   input  logic        flush_i,
   input  logic [31:0] flush_target_i,
   output logic [31:0] imem_addr_o,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] instr_fetch_o,
   output logic [31:0] pc_fetch_o,
   output logic        valid_fetch_o,
   output logic        halted_o,
   output logic        misalign_o,
   output logic [31:0] perf_fetch_o,
   output logic [31:0] perf_stall_o,
   output logic [31:0] perf_flush_o
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_next;
   logic         ifid_load, ifid_bubble;
   logic         cnt_fetch, cnt_stall, cnt_flush;
   logic         misalign_d;

   // Next-state, next-PC and IF/ID update selection
   always_comb begin
      state_d     = state_q;
      pc_next     = pc_q;
      ifid_load   = 1'b0;
      ifid_bubble = 1'b0;
      cnt_fetch   = 1'b0;
      cnt_stall   = 1'b0;
      cnt_flush   = 1'b0;
      misalign_d  = 1'b0;
      case (state_q)
         BOOT: begin
            ifid_bubble = 1'b1;
            state_d     = RUN;
            if (flush_i) begin
               pc_next    = align_word(flush_target_i);
               cnt_flush  = 1'b1;
               misalign_d = |flush_target_i[1:0];
            end else begin
               pc_next = RESET_PC;
            end
         end
         RUN: begin
            if (flush_i) begin
               pc_next     = align_word(flush_target_i);
               ifid_bubble = 1'b1;
               cnt_flush   = 1'b1;
               misalign_d  = |flush_target_i[1:0];
            end else if (stall_en_i) begin
               pc_next   = pc_q;
               cnt_stall = 1'b1;
            end else begin
               pc_next   = pc_q + 32'd4;
               ifid_load = 1'b1;
               cnt_fetch = 1'b1;
               if (HALT_ON_EBREAK && (imem_rdata_i == EBREAK_INSTR))
                  state_d = HALT;
            end
         end
         HALT: begin
            if (flush_i) begin
               pc_next     = align_word(flush_target_i);
               ifid_bubble = 1'b1;
               cnt_flush   = 1'b1;
               misalign_d  = |flush_target_i[1:0];
               state_d     = RUN;
            end else begin
               pc_next     = pc_q;
               ifid_bubble = !stall_en_i;
            end
         end
         default: begin
            state_d = BOOT;
            pc_next = RESET_PC;
         end
      endcase
   end

   // The memory is addressed with the PC being launched this cycle
   assign imem_addr_o = rstn_i ? pc_next : RESET_PC;
   assign halted_o    = (state_q == HALT);

   // State, PC and IF/ID pipeline register
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q       <= BOOT;
         pc_q          <= RESET_PC;
         instr_fetch_o <= NOP_INSTR;
         pc_fetch_o    <= 32'd0;
         valid_fetch_o <= 1'b0;
         misalign_o    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_next;
         misalign_o <= misalign_d;
         if (ifid_bubble) begin
            instr_fetch_o <= NOP_INSTR;
            pc_fetch_o    <= 32'd0;
            valid_fetch_o <= 1'b0;
         end else if (ifid_load) begin
            instr_fetch_o <= imem_rdata_i;
            pc_fetch_o    <= pc_q;
            valid_fetch_o <= 1'b1;
         end
      end
   end

   fetch_perf_cnt u_perf (
      .clk_i        (clk_i),
      .rstn_i       (rstn_i),
      .fetch_en_i   (cnt_fetch),
      .stall_en_i   (cnt_stall),
      .flush_en_i   (cnt_flush),
      .perf_fetch_o (perf_fetch_o),
      .perf_stall_o (perf_stall_o),
      .perf_flush_o (perf_flush_o)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

   localparam logic [31:0] RST_PC = 32'h0000_0080;
   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] EBRK   = 32'h0010_0073;

   logic        clk = 1'b0;
   logic        rstn;
   logic        stall_en;
   logic        flush;
   logic [31:0] flush_target;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] instr_fetch;
   logic [31:0] pc_fetch;
   logic        valid_fetch;
   logic        halted;
   logic        misalign;
   logic [31:0] perf_fetch;
   logic [31:0] perf_stall;
   logic [31:0] perf_flush;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic        stall;
      logic        flush;
      logic [31:0] target;
      logic [31:0] addr;
      logic [31:0] instr;
      logic [31:0] pc;
      logic        valid;
      logic        halted;
      logic        mis;
   } vec_t;

   vec_t vecs[20];
   vec_t sb[$];

   fetch_stage #(
      .RESET_PC       (RST_PC),
      .NOP_INSTR      (NOP),
      .HALT_ON_EBREAK (1'b1)
   ) dut (
      .clk_i          (clk),
      .rstn_i         (rstn),
      .stall_en_i     (stall_en),
      .flush_i        (flush),
      .flush_target_i (flush_target),
      .imem_addr_o    (imem_addr),
      .imem_rdata_i   (imem_rdata),
      .instr_fetch_o  (instr_fetch),
      .pc_fetch_o     (pc_fetch),
      .valid_fetch_o  (valid_fetch),
      .halted_o       (halted),
      .misalign_o     (misalign),
      .perf_fetch_o   (perf_fetch),
      .perf_stall_o   (perf_stall),
      .perf_flush_o   (perf_flush)
   );

   always #5 clk = ~clk;

   // ROM: each word holds its own address, except an EBREAK at 0x90
   always @(posedge clk) imem_rdata <= (imem_addr == 32'h90) ? EBRK : imem_addr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic s, input logic f, input logic [31:0] t,
                               input logic [31:0] a, input logic [31:0] ins,
                               input logic [31:0] p, input logic v, input logic h,
                               input logic m);
      vec_t r;
      r.stall = s; r.flush = f; r.target = t; r.addr = a; r.instr = ins;
      r.pc = p; r.valid = v; r.halted = h; r.mis = m;
      return r;
   endfunction

   task automatic check_reset_state();
      check("rst_instr",  instr_fetch, NOP);
      check("rst_pc",     pc_fetch, 32'd0);
      check("rst_valid",  {31'd0, valid_fetch}, 32'd0);
      check("rst_halted", {31'd0, halted}, 32'd0);
      check("rst_mis",    {31'd0, misalign}, 32'd0);
      check("rst_addr",   imem_addr, RST_PC);
      check("rst_pfetch", perf_fetch, 32'd0);
      check("rst_pstall", perf_stall, 32'd0);
      check("rst_pflush", perf_flush, 32'd0);
   endtask

   // Called just after a falling edge: drive, check address, clock, check IF/ID
   task automatic apply_step(input int idx, input vec_t v);
      vec_t e;
      stall_en     = v.stall;
      flush        = v.flush;
      flush_target = v.target;
      sb.push_back(v);
      #1;
      check($sformatf("addr[%0d]", idx), imem_addr, v.addr);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL sb_empty[%0d]: got 0 entries expected 1", idx);
      end else begin
         e = sb.pop_front();
         check($sformatf("instr[%0d]", idx), instr_fetch, e.instr);
         check($sformatf("pc[%0d]", idx), pc_fetch, e.pc);
         check($sformatf("valid[%0d]", idx), {31'd0, valid_fetch}, {31'd0, e.valid});
         check($sformatf("halted[%0d]", idx), {31'd0, halted}, {31'd0, e.halted});
         check($sformatf("mis[%0d]", idx), {31'd0, misalign}, {31'd0, e.mis});
      end
      @(negedge clk);
   endtask

   initial begin
      //              stall flush target   addr    instr   pc      v h m
      vecs[0]  = mk(0, 0, 32'h0,   32'h80,  NOP,    32'h0,   0, 0, 0);
      vecs[1]  = mk(0, 0, 32'h0,   32'h84,  32'h80, 32'h80,  1, 0, 0);
      vecs[2]  = mk(0, 0, 32'h0,   32'h88,  32'h84, 32'h84,  1, 0, 0);
      vecs[3]  = mk(1, 0, 32'h0,   32'h88,  32'h84, 32'h84,  1, 0, 0);
      vecs[4]  = mk(1, 0, 32'h0,   32'h88,  32'h84, 32'h84,  1, 0, 0);
      vecs[5]  = mk(0, 0, 32'h0,   32'h8C,  32'h88, 32'h88,  1, 0, 0);
      vecs[6]  = mk(0, 0, 32'h0,   32'h90,  32'h8C, 32'h8C,  1, 0, 0);
      vecs[7]  = mk(1, 1, 32'h200, 32'h200, NOP,    32'h0,   0, 0, 0);
      vecs[8]  = mk(0, 0, 32'h0,   32'h204, 32'h200,32'h200, 1, 0, 0);
      vecs[9]  = mk(0, 1, 32'h203, 32'h200, NOP,    32'h0,   0, 0, 1);
      vecs[10] = mk(0, 0, 32'h0,   32'h204, 32'h200,32'h200, 1, 0, 0);
      vecs[11] = mk(0, 1, 32'h88,  32'h88,  NOP,    32'h0,   0, 0, 0);
      vecs[12] = mk(0, 0, 32'h0,   32'h8C,  32'h88, 32'h88,  1, 0, 0);
      vecs[13] = mk(0, 0, 32'h0,   32'h90,  32'h8C, 32'h8C,  1, 0, 0);
      vecs[14] = mk(0, 0, 32'h0,   32'h94,  EBRK,   32'h90,  1, 1, 0);
      vecs[15] = mk(0, 0, 32'h0,   32'h94,  NOP,    32'h0,   0, 1, 0);
      vecs[16] = mk(0, 0, 32'h0,   32'h94,  NOP,    32'h0,   0, 1, 0);
      vecs[17] = mk(0, 1, 32'h100, 32'h100, NOP,    32'h0,   0, 0, 0);
      vecs[18] = mk(0, 0, 32'h0,   32'h104, 32'h100,32'h100, 1, 0, 0);
      vecs[19] = mk(0, 0, 32'h0,   32'h108, 32'h104,32'h104, 1, 0, 0);

      rstn = 1'b0; stall_en = 1'b0; flush = 1'b0; flush_target = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_state();

      @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 20; i++) begin
         apply_step(i, vecs[i]);
         if (i == 6) begin
            check("stall_cnt_after_stall", perf_stall, 32'd2);
            check("fetch_cnt_after_stall", perf_fetch, 32'd4);
         end
         if (i == 7) begin
            check("flush_cnt_first", perf_flush, 32'd1);
            check("stall_cnt_on_flush", perf_stall, 32'd2);
         end
      end
      check("perf_fetch_end", perf_fetch, 32'd11);
      check("perf_stall_end", perf_stall, 32'd2);
      check("perf_flush_end", perf_flush, 32'd4);

      // Reset dropped between edges takes effect without a clock
      stall_en = 1'b0; flush = 1'b0;
      @(posedge clk);
      #3;
      rstn = 1'b0;
      #1;
      check_reset_state();
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 3; i++) apply_step(100 + i, vecs[i]);
      check("perf_fetch_after_rst", perf_fetch, 32'd2);
      check("perf_flush_after_rst", perf_flush, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the RV32I 5-stage core.
- Owns the PC, drives the synchronous instruction memory, and presents the instruction entering decode (instr_fetch_o) with its PC.
- Consumes stall_en and flush from the hazard unit:
  - stall freezes PC and IF/ID.
  - flush redirects the PC and injects a bubble.
- Also provides EBREAK halt and fetch performance counters.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned).
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0).
- HALT_ON_EBREAK, 1, when 1 a fetched EBREAK (32'h0010_0073) halts fetch.

Ports:
- clk_i  in  1  clock, rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- stall_en_i  in  1  hazard unit load-use stall; hold PC and IF/ID.
- flush_i  in  1  hazard unit flush (branch/jump taken in execute).
- flush_target_i  in  32  redirect address, valid when flush_i=1.
- imem_addr_o  out  32  imem read address; data returns next cycle.
- imem_rdata_i  in  32  imem read data for the address of the previous cycle.
- instr_fetch_o  out  32  IF/ID instruction to decode.
- pc_fetch_o  out  32  IF/ID PC.
- valid_fetch_o  out  1  IF/ID holds a real instruction (0 for bubble).
- halted_o  out  1  fetch halted on EBREAK.
- misalign_o  out  1  one-cycle pulse: flush target had bits [1:0] != 0.
- perf_fetch_o  out  32  count of valid instructions latched into IF/ID.
- perf_stall_o  out  32  count of stall cycles.
- perf_flush_o  out  32  count of flush cycles.

Behaviour:
- Reset (asynchronous, on rstn_i=0) sets all registers at once:
  - state=BOOT, pc_q=RESET_PC.
  - instr_fetch_o=NOP_INSTR, pc_fetch_o=0, valid_fetch_o=0.
  - halted_o=0, misalign_o=0, all counters 0.
- imem_addr_o is combinational:
  - equals RESET_PC in BOOT and during reset;
  - otherwise equals pc_next.
- pc_q is the address whose data is on imem_rdata_i this cycle.
- State machine: BOOT, RUN, HALT.
- BOOT (first cycle after reset):
  - imem_addr_o=RESET_PC; IF/ID <= bubble; pc_q <= RESET_PC; go to RUN.
  - If flush_i=1 in BOOT, flush wins: pc_q <= aligned target; go to RUN.
- RUN, one rule per cycle, in priority order:
  1. flush_i=1 (wins over stall):
     - pc_next = {flush_target_i[31:2],2'b00}.
     - IF/ID <= {NOP_INSTR, pc 0, valid 0}.
     - perf_flush++; misalign_o=1 next cycle if target[1:0] != 0.
  2. stall_en_i=1:
     - pc_next = pc_q, so the same address is re-read.
     - IF/ID holds all fields; perf_stall++.
  3. Otherwise:
     - pc_next = pc_q + 4, wrapping modulo 2^32.
     - IF/ID <= {imem_rdata_i, pc_q, 1}; perf_fetch++.
     - If HALT_ON_EBREAK=1 and imem_rdata_i == 32'h0010_0073, go to HALT.
  - pc_q <= pc_next in every case.
- HALT:
  - halted_o=1; pc_q frozen; imem_addr_o=pc_q.
  - IF/ID <= bubble unless stall_en_i=1, in which case IF/ID holds, so the EBREAK still drains.
  - flush_i=1 gives the RUN flush behaviour, clears halted_o and returns to RUN.
  - Otherwise only reset leaves HALT.
- Guarantees:
  - No instruction is lost or duplicated across any stall length.
  - Exactly one bubble follows each flush; the target instruction appears two cycles after the flush cycle.
- Counters wrap silently at 2^32. A flush cycle never counts as a stall.
- misalign_o is a single-cycle registered pulse; it is not sticky.

Decomposition:
- Shared package rv32_pkg:
  - opcode constants (LOAD, STORE, BRANCH, JAL, JALR, SYSTEM);
  - NOP_INSTR and EBREAK_INSTR constants;
  - typedef enum fetch_state_t {BOOT, RUN, HALT}.
- One sub-module: fetch_perf_cnt, three 32-bit enable-gated counters with async active-low reset.

Test Plan:
1. RESET_PC=0x80, ROM word at addr a = a, release reset:
   - cycle 1: imem_addr_o=0x80, IF/ID bubble.
   - cycle 2: instr=0x80, pc=0x80, valid=1.
   - then 0x84, 0x88 on consecutive cycles.
2. stall_en_i=1 for 2 cycles while pc_fetch_o=0x84:
   - IF/ID held 2 cycles and imem_addr_o held;
   - then 0x88, 0x8C with no gap or repeat; perf_stall_o=2.
3. flush_i=1 with target 0x200 together with stall_en_i=1:
   - next cycle: instr=0x13, valid=0.
   - following cycle: pc=0x200, valid=1.
   - perf_flush_o=1, perf_stall_o unchanged.
4. flush target 0x203:
   - fetch resumes at 0x200; misalign_o high exactly one cycle.
5. ROM holds EBREAK at 0x90:
   - IF/ID shows 0x0010_0073 valid, then bubbles; halted_o=1; imem_addr_o constant.
   - flush target 0x100 gives halted_o=0 and fetch resumes at 0x100.
6. Assert rstn_i low between clock edges mid-run:
   - outputs take reset values immediately; counters read 0.
   - after release, the sequence of scenario 1 repeats.
